// File: rtl/gray_pkg.sv
// Purpose: shared Gray/binary conversion helpers and width limit for the Gray counter family.
// Latency: pure functions, no state.
// Backpressure: not applicable.
package gray_pkg;

  // Widest counter the helpers support; callers zero-extend narrower values.
  localparam int GRAY_MAX_W = 16;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin_to_gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB down. Zero-extended upper bits leave the lower
  // bits unaffected, so callers may truncate the result to their own width.
  function automatic gray_word_t gray_to_bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_n_if.sv
// Purpose: command/status bundle between a Gray counter and its user.
// Latency: wires only.
// Backpressure: none; the counter accepts a command every cycle.
// Ports (master side drives): en, up, load, load_gray; (slave side drives): gray, bin, tc.
interface gray_counter_n_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_gray;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin;
  logic             tc;

  modport master (
    output en, up, load, load_gray,
    input  gray, bin, tc
  );

  modport slave (
    input  en, up, load, load_gray,
    output gray, bin, tc
  );
endinterface

// File: rtl/gray_to_bin.sv
// Purpose: combinational Gray-to-binary converter for the load path.
// Latency: 0 cycles (combinational).
// Backpressure: none.
// Ports: gray_i (Gray-coded in), bin_o (binary out), both WIDTH bits.
module gray_to_bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);
  localparam int MW = gray_pkg::GRAY_MAX_W;

  assign bin_o = WIDTH'(gray_pkg::gray_to_bin(MW'(gray_i)));
endmodule

// File: rtl/gray_counter_n.sv
// Purpose: WIDTH-bit up/down Gray counter with load, wrap or saturate, registered terminal-count pulse.
// Latency: 1 cycle from load/en edge to gray/bin/tc; no combinational input-to-output path.
// Backpressure: none; a step is taken on every enabled cycle.
// Ports: clk, rst_n (async active-low); bus (slave): en, up, load, load_gray in; gray, bin, tc out.
module gray_counter_n #(
  parameter int WIDTH = 3,      // 2..16
  parameter bit WRAP  = 1'b1    // 1 = wrap at terminal, 0 = hold at terminal
) (
  input  logic             clk,
  input  logic             rst_n,
  gray_counter_n_if.slave  bus
);
  import gray_pkg::*;

  localparam logic [WIDTH-1:0] B_ZERO = '0;
  localparam logic [WIDTH-1:0] B_MAX  = '1;
  localparam logic [WIDTH-1:0] B_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] b_d, b_q;
  logic [WIDTH-1:0] gray_d, gray_q;
  logic             tc_d, tc_q;
  logic             at_term;

  gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
    .gray_i (bus.load_gray),
    .bin_o  (load_bin)
  );

  always_comb begin
    b_d     = b_q;
    tc_d    = 1'b0;
    // Terminal depends on the direction sampled this cycle.
    at_term = bus.up ? (b_q == B_MAX) : (b_q == B_ZERO);

    if (bus.load) begin
      b_d = load_bin;
    end else if (bus.en) begin
      if (at_term) begin
        // tc fires on the wrapping step, or on every enabled cycle while saturated.
        tc_d = 1'b1;
        if (WRAP) begin
          b_d = bus.up ? B_ZERO : B_MAX;
        end
      end else begin
        b_d = bus.up ? (b_q + B_ONE) : (b_q - B_ONE);
      end
    end

    // Gray is registered from the next binary value so both outputs change on the same edge.
    gray_d = WIDTH'(bin_to_gray(GRAY_MAX_W'(b_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q    <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      b_q    <= b_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bus.gray = gray_q;
  assign bus.bin  = b_q;
  assign bus.tc   = tc_q;

endmodule
